// File: rtl/grant_arb_pkg.sv
// Shared types and default timing constants for the bounded-grant arbiters.
package grant_arb_pkg;

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

    localparam int DEF_MIN_HOLD = 2;
    localparam int DEF_MAX_HOLD = 6;
    localparam int DEF_GAP      = 1;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_picker #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   sel,
    output logic            any
);

    logic [IW-1:0] idx;

    // Walk from farthest to nearest so the closest set bit to ptr wins last.
    always_comb begin
        sel = '0;
        any = 1'b0;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % NREQ);
            if (req[idx]) begin
                sel = idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bounded_grant_arbiter.sv
// Round-robin arbiter whose grants last MIN_HOLD..MAX_HOLD cycles, followed by a GAP-cycle idle.
module bounded_grant_arbiter
    import grant_arb_pkg::state_t, grant_arb_pkg::IDLE, grant_arb_pkg::HOLD,
           grant_arb_pkg::DEF_MIN_HOLD, grant_arb_pkg::DEF_MAX_HOLD, grant_arb_pkg::DEF_GAP;
#(
    parameter int NREQ     = 4,
    parameter int MIN_HOLD = DEF_MIN_HOLD,
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int GAP      = DEF_GAP
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req,
    output logic [NREQ-1:0]               gnt,
    output logic                          gnt_active,
    output logic [$clog2(NREQ)-1:0]       gnt_id,
    output logic [$clog2(MAX_HOLD+1)-1:0] hold_cnt,
    output logic                          timeout
);

    localparam int IW = $clog2(NREQ);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    state_t          state, state_n;
    logic [IW-1:0]   ptr, ptr_n, sel, gnt_id_n;
    logic [NREQ-1:0] gnt_n;
    logic [HW-1:0]   hold_n;
    logic [GW-1:0]   gap_cnt, gap_n;
    logic            timeout_n, any, arb, rel;

    rr_picker #(.NREQ(NREQ)) u_picker (
        .req (req),
        .ptr (ptr),
        .sel (sel),
        .any (any)
    );

    always_comb begin
        state_n   = state;
        gnt_n     = gnt;
        gnt_id_n  = gnt_id;
        hold_n    = hold_cnt;
        ptr_n     = ptr;
        gap_n     = gap_cnt;
        timeout_n = 1'b0;
        arb       = 1'b0;
        rel       = (hold_cnt >= HW'(MIN_HOLD) && !req[gnt_id]) || hold_cnt == HW'(MAX_HOLD);

        case (state)
            IDLE: arb = 1'b1;
            HOLD: begin
                if (rel) begin
                    gnt_n     = '0;
                    hold_n    = '0;
                    ptr_n     = (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
                    gap_n     = GW'(GAP - 1);
                    timeout_n = (hold_cnt == HW'(MAX_HOLD)) && req[gnt_id];
                    state_n   = grant_arb_pkg::GAP;
                end else begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            grant_arb_pkg::GAP: begin
                // The edge closing the last gap cycle already arbitrates, so the low time is exactly GAP.
                if (gap_cnt == '0) begin
                    state_n = IDLE;
                    arb     = 1'b1;
                end else begin
                    gap_n = gap_cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (arb && any) begin
            gnt_n      = '0;
            gnt_n[sel] = 1'b1;
            gnt_id_n   = sel;
            hold_n     = HW'(1);
            state_n    = HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            hold_cnt <= '0;
            timeout  <= 1'b0;
            ptr      <= '0;
            gap_cnt  <= '0;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            gnt_id   <= gnt_id_n;
            hold_cnt <= hold_n;
            timeout  <= timeout_n;
            ptr      <= ptr_n;
            gap_cnt  <= gap_n;
        end
    end

    assign gnt_active = |gnt;

endmodule
